ntt_bitrev_loader: RTL

// - Input stage for the 8-point butterfly network: accepts natural-order coefficients serially
//   (one per valid/ready beat), reduces each into [0,mod) and stores it at its bit-reversed address.
// - Presents each complete frame as a parallel, bit-reversed vector, which the combinational network consumes.
// - Ping-pong double buffer: one bank fills while the other is held for the consumer, so the block streams at full rate.

---
 rtl/ntt_pkg.sv | 21 ++
 rtl/ntt_bitrev_loader_if.sv | 26 ++
 rtl/ntt_frame_bank.sv | 61 ++++++
 rtl/ntt_bitrev_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, bank state type and the bit-reverse helper for the NTT datapath.
package ntt_pkg;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int LOGN = 3;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_e;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bitrev_loader_if.sv
// Serial coefficient input and parallel frame output of the bit-reverse loader.
interface ntt_bitrev_loader_if;
  import ntt_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic [W-1:0]   mod;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [W-1:0]   out_mod;
  logic           err;

  modport slave (
    input  in_valid, in_data, in_last, mod, out_ready,
    output in_ready, out_valid, out_data, out_mod, err
  );

  modport master (
    output in_valid, in_data, in_last, mod, out_ready,
    input  in_ready, out_valid, out_data, out_mod, err
  );

endinterface

// File: rtl/ntt_frame_bank.sv
// One ping-pong bank: N reduced words at bit-reversed addresses, the frame modulus and a FREE/FULL flag.
module ntt_frame_bank
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [LOGN-1:0] wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            mod_en,
  input  logic [W-1:0]    mod_in,
  input  logic            close_en,
  input  logic            release_en,
  output bank_state_e     state,
  output logic [N*W-1:0]  vec,
  output logic [W-1:0]    mod_out
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  logic [W-1:0] mod_q, mod_d;
  bank_state_e  state_q, state_d;

  always_comb begin
    mem_d   = mem_q;
    mod_d   = mod_q;
    state_d = state_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    if (mod_en) begin
      mod_d = mod_in;
    end
    // Close and release never target the same bank in one cycle.
    if (close_en) begin
      state_d = FULL;
    end else if (release_en) begin
      state_d = FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      mod_q   <= '0;
      state_q <= FREE;
    end else begin
      mem_q   <= mem_d;
      mod_q   <= mod_d;
      state_q <= state_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_vec
    assign vec[gi*W +: W] = mem_q[gi];
  end

  assign state   = state_q;
  assign mod_out = mod_q;

endmodule

// File: rtl/ntt_bitrev_loader.sv
// Serial-to-parallel bit-reversing loader with modular pre-reduction and a ping-pong frame buffer.
module ntt_bitrev_loader
  import ntt_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  ntt_bitrev_loader_if.slave  bus
);

  logic [LOGN-1:0] cnt_q, cnt_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic            err_q, err_d;

  bank_state_e     bank_state [2];
  logic [N*W-1:0]  bank_vec   [2];
  logic [W-1:0]    bank_mod   [2];

  logic            in_fire;
  logic            out_fire;
  logic            first_beat;
  logic            last_beat;
  logic            over;
  logic [W-1:0]    mod_cur;
  logic [W-1:0]    red_data;
  logic [LOGN-1:0] wr_addr;
  logic [W:0]      din_ext;
  logic [W:0]      mod_ext;

  assign bus.in_ready  = (bank_state[wr_sel_q] != FULL);
  assign bus.out_valid = (bank_state[rd_sel_q] == FULL);
  assign bus.out_data  = bank_vec[rd_sel_q];
  assign bus.out_mod   = bank_mod[rd_sel_q];
  assign bus.err       = err_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // The first beat reduces against the live modulus; later beats use the one latched with the frame.
  always_comb begin
    first_beat = (cnt_q == '0);
    last_beat  = (cnt_q == LOGN'(N-1));
    wr_addr    = bitrev(cnt_q);
    mod_cur    = first_beat ? bus.mod : bank_mod[wr_sel_q];
    din_ext    = {1'b0, bus.in_data};
    mod_ext    = {1'b0, mod_cur};
    red_data   = (din_ext >= mod_ext) ? W'(din_ext - mod_ext) : bus.in_data;
    over       = (din_ext >= {mod_cur, 1'b0});
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    if (in_fire) begin
      // N is a power of two, so the increment wraps to 0 on the closing beat.
      cnt_d = cnt_q + LOGN'(1);
      if (last_beat) begin
        wr_sel_d = ~wr_sel_q;
      end
      if (over || (bus.in_last != last_beat)) begin
        err_d = 1'b1;
      end
    end
    if (out_fire) begin
      rd_sel_d = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic wr_hit;
    logic rd_hit;
    assign wr_hit = in_fire && (wr_sel_q == 1'(gi));
    assign rd_hit = out_fire && (rd_sel_q == 1'(gi));

    ntt_frame_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_hit),
      .wr_addr    (wr_addr),
      .wr_data    (red_data),
      .mod_en     (wr_hit && first_beat),
      .mod_in     (bus.mod),
      .close_en   (wr_hit && last_beat),
      .release_en (rd_hit),
      .state      (bank_state[gi]),
      .vec        (bank_vec[gi]),
      .mod_out    (bank_mod[gi])
    );
  end

endmodule
